// File: rtl/hazard_ctrl_unit.sv
// Pipeline control brain: opcode decode, forwarding selects,
// load/branch hazard stall FSM and saturating event counters.
module hazard_ctrl_unit #(
    parameter int RST_HOLD = 2,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [5:0]       OpCode,
    input  logic [4:0]       IfId_Rs,
    input  logic [4:0]       IfId_Rt,
    input  logic [4:0]       IdEx_Rs,
    input  logic [4:0]       IdEx_Rt,
    input  logic [4:0]       IdEx_WrReg,
    input  logic             IdEx_Reg_Wr_Control,
    input  logic             IdEx_MemRead,
    input  logic [4:0]       ExMem_Rd,
    input  logic             ExMem_Reg_Wr_Control,
    input  logic             ExMem_MemRead,
    input  logic [4:0]       MemWb_Rd,
    input  logic             MemWb_Reg_Wr_Control,
    input  logic             Ctrl_Branch,
    output logic             RegDst,
    output logic             Jump,
    output logic             Branch,
    output logic             MemRead,
    output logic             MemtoReg,
    output logic             MemWrite,
    output logic             ALU_Src,
    output logic             RegWrite,
    output logic [1:0]       Alu_Op,
    output logic [1:0]       FwdRs,
    output logic [1:0]       FwdRt,
    output logic [1:0]       Fwd_IfId_Rs,
    output logic [1:0]       Fwd_IfId_Rt,
    output logic             Stall,
    output logic             Flush,
    output logic             FwdPc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {HOLD, RUN, BR2} state_t;

    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD - 1);

    state_t        state, state_nx;
    logic [HW-1:0] hold_cnt, hold_nx;

    logic       d_regdst, d_jump, d_branch, d_memread;
    logic       d_memtoreg, d_memwrite, d_alusrc, d_regwrite;
    logic [1:0] d_aluop;
    logic       uses_rt;
    logic       lu, bex, bmem, redirect;

    always_comb begin
        d_regdst   = 1'b0;
        d_jump     = 1'b0;
        d_branch   = 1'b0;
        d_memread  = 1'b0;
        d_memtoreg = 1'b0;
        d_memwrite = 1'b0;
        d_alusrc   = 1'b0;
        d_regwrite = 1'b0;
        d_aluop    = 2'b00;
        uses_rt    = 1'b0;
        case (OpCode)
            6'b000000: begin
                d_regdst   = 1'b1;
                d_regwrite = 1'b1;
                d_aluop    = 2'b10;
                uses_rt    = 1'b1;
            end
            6'b100011: begin
                d_alusrc   = 1'b1;
                d_memread  = 1'b1;
                d_memtoreg = 1'b1;
                d_regwrite = 1'b1;
            end
            6'b101011: begin
                d_alusrc   = 1'b1;
                d_memwrite = 1'b1;
                uses_rt    = 1'b1;
            end
            6'b001000: begin
                d_alusrc   = 1'b1;
                d_regwrite = 1'b1;
            end
            6'b000100: begin
                d_branch = 1'b1;
                d_aluop  = 2'b01;
                uses_rt  = 1'b1;
            end
            6'b000010: d_jump = 1'b1;
            default: ;
        endcase
    end

    // A stalled instruction leaves as a bubble: every control dropped.
    assign RegDst   = d_regdst   & ~Stall;
    assign Jump     = d_jump     & ~Stall;
    assign Branch   = d_branch   & ~Stall;
    assign MemRead  = d_memread  & ~Stall;
    assign MemtoReg = d_memtoreg & ~Stall;
    assign MemWrite = d_memwrite & ~Stall;
    assign ALU_Src  = d_alusrc   & ~Stall;
    assign RegWrite = d_regwrite & ~Stall;
    assign Alu_Op   = Stall ? 2'b00 : d_aluop;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       em_wr,
        input logic [4:0] em_rd,
        input logic       mw_wr,
        input logic [4:0] mw_rd
    );
        if (em_wr && em_rd != 5'd0 && em_rd == src)
            return 2'b10;
        else if (mw_wr && mw_rd != 5'd0 && mw_rd == src)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign FwdRs = fwd_sel(IdEx_Rs, ExMem_Reg_Wr_Control, ExMem_Rd,
                           MemWb_Reg_Wr_Control, MemWb_Rd);
    assign FwdRt = fwd_sel(IdEx_Rt, ExMem_Reg_Wr_Control, ExMem_Rd,
                           MemWb_Reg_Wr_Control, MemWb_Rd);
    assign Fwd_IfId_Rs = fwd_sel(IfId_Rs, ExMem_Reg_Wr_Control, ExMem_Rd,
                                 MemWb_Reg_Wr_Control, MemWb_Rd);
    assign Fwd_IfId_Rt = fwd_sel(IfId_Rt, ExMem_Reg_Wr_Control, ExMem_Rd,
                                 MemWb_Reg_Wr_Control, MemWb_Rd);

    assign lu = IdEx_MemRead && IdEx_WrReg != 5'd0 &&
                (IdEx_WrReg == IfId_Rs ||
                 (uses_rt && IdEx_WrReg == IfId_Rt));
    assign bex = d_branch && IdEx_Reg_Wr_Control && !IdEx_MemRead &&
                 IdEx_WrReg != 5'd0 &&
                 (IdEx_WrReg == IfId_Rs || IdEx_WrReg == IfId_Rt);
    assign bmem = d_branch && ExMem_MemRead && ExMem_Rd != 5'd0 &&
                  (ExMem_Rd == IfId_Rs || ExMem_Rd == IfId_Rt);
    assign redirect = d_jump | (d_branch & Ctrl_Branch);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= HOLD;
            hold_cnt <= HOLD_INIT;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;
        end
    end

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        Stall    = 1'b0;
        Flush    = 1'b0;
        FwdPc    = 1'b0;
        case (state)
            HOLD: begin
                Stall = 1'b1;
                Flush = 1'b1;
                if (hold_cnt == '0)
                    state_nx = RUN;
                else
                    hold_nx = hold_cnt - 1'b1;
            end
            RUN: begin
                Stall = lu | bex | bmem;
                FwdPc = ~Stall & redirect;
                Flush = FwdPc;
                // Load feeding a beq needs a second bubble for the ID compare.
                if (lu && d_branch)
                    state_nx = BR2;
            end
            BR2: begin
                Stall    = 1'b1;
                state_nx = RUN;
            end
            default: state_nx = HOLD;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (Stall && state != HOLD && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (FwdPc && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: a behavioural model pushes
// expected outputs per cycle, compared once the DUT has settled.
module tb_hazard_ctrl_unit;

    localparam int RST_HOLD = 2;

    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] OpCode;
    logic [4:0] IfId_Rs, IfId_Rt, IdEx_Rs, IdEx_Rt, IdEx_WrReg;
    logic       IdEx_Reg_Wr_Control, IdEx_MemRead;
    logic [4:0] ExMem_Rd, MemWb_Rd;
    logic       ExMem_Reg_Wr_Control, ExMem_MemRead;
    logic       MemWb_Reg_Wr_Control, Ctrl_Branch;

    logic        RegDst, Jump, Branch, MemRead, MemtoReg;
    logic        MemWrite, ALU_Src, RegWrite;
    logic [1:0]  Alu_Op, FwdRs, FwdRt, Fwd_IfId_Rs, Fwd_IfId_Rt;
    logic        Stall, Flush, FwdPc;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_regdst, s_jump, s_branch, s_memread, s_memtoreg;
    logic        s_memwrite, s_alusrc, s_regwrite;
    logic [1:0]  s_aluop, s_fwdrs, s_fwdrt, s_fwdidrs, s_fwdidrt;
    logic        s_stall, s_flush, s_fwdpc;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    hazard_ctrl_unit #(.RST_HOLD(RST_HOLD), .CNT_W(16)) u_dut (
        .CLK(CLK), .RST(RST), .OpCode(OpCode),
        .IfId_Rs(IfId_Rs), .IfId_Rt(IfId_Rt),
        .IdEx_Rs(IdEx_Rs), .IdEx_Rt(IdEx_Rt), .IdEx_WrReg(IdEx_WrReg),
        .IdEx_Reg_Wr_Control(IdEx_Reg_Wr_Control),
        .IdEx_MemRead(IdEx_MemRead), .ExMem_Rd(ExMem_Rd),
        .ExMem_Reg_Wr_Control(ExMem_Reg_Wr_Control),
        .ExMem_MemRead(ExMem_MemRead), .MemWb_Rd(MemWb_Rd),
        .MemWb_Reg_Wr_Control(MemWb_Reg_Wr_Control),
        .Ctrl_Branch(Ctrl_Branch),
        .RegDst(RegDst), .Jump(Jump), .Branch(Branch), .MemRead(MemRead),
        .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALU_Src(ALU_Src),
        .RegWrite(RegWrite), .Alu_Op(Alu_Op), .FwdRs(FwdRs), .FwdRt(FwdRt),
        .Fwd_IfId_Rs(Fwd_IfId_Rs), .Fwd_IfId_Rt(Fwd_IfId_Rt),
        .Stall(Stall), .Flush(Flush), .FwdPc(FwdPc),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter instance to exercise saturation quickly.
    hazard_ctrl_unit #(.RST_HOLD(RST_HOLD), .CNT_W(2)) u_dut_sat (
        .CLK(CLK), .RST(RST), .OpCode(OpCode),
        .IfId_Rs(IfId_Rs), .IfId_Rt(IfId_Rt),
        .IdEx_Rs(IdEx_Rs), .IdEx_Rt(IdEx_Rt), .IdEx_WrReg(IdEx_WrReg),
        .IdEx_Reg_Wr_Control(IdEx_Reg_Wr_Control),
        .IdEx_MemRead(IdEx_MemRead), .ExMem_Rd(ExMem_Rd),
        .ExMem_Reg_Wr_Control(ExMem_Reg_Wr_Control),
        .ExMem_MemRead(ExMem_MemRead), .MemWb_Rd(MemWb_Rd),
        .MemWb_Reg_Wr_Control(MemWb_Reg_Wr_Control),
        .Ctrl_Branch(Ctrl_Branch),
        .RegDst(s_regdst), .Jump(s_jump), .Branch(s_branch),
        .MemRead(s_memread), .MemtoReg(s_memtoreg), .MemWrite(s_memwrite),
        .ALU_Src(s_alusrc), .RegWrite(s_regwrite), .Alu_Op(s_aluop),
        .FwdRs(s_fwdrs), .FwdRt(s_fwdrt),
        .Fwd_IfId_Rs(s_fwdidrs), .Fwd_IfId_Rt(s_fwdidrt),
        .Stall(s_stall), .Flush(s_flush), .FwdPc(s_fwdpc),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [9:0]  ctl;
        logic [7:0]  fwd;
        logic [2:0]  sfp;
        logic [15:0] scnt;
        logic [15:0] fcnt;
        logic [1:0]  scnt2;
    } exp_t;

    exp_t sb[$];
    int   errs = 0;
    int   checks = 0;
    int   m_st, m_hold, m_scnt, m_fcnt, m_scnt2;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] dec(input logic [5:0] op);
        case (op)
            6'b000000: return 10'b1000000110;
            6'b100011: return 10'b0001101100;
            6'b101011: return 10'b0000011000;
            6'b001000: return 10'b0000001100;
            6'b000100: return 10'b0010000001;
            6'b000010: return 10'b0100000000;
            default:   return 10'b0000000000;
        endcase
    endfunction

    function automatic logic [1:0] fsel(input logic [4:0] src);
        if (ExMem_Reg_Wr_Control && ExMem_Rd != 0 && ExMem_Rd == src)
            return 2'b10;
        if (MemWb_Reg_Wr_Control && MemWb_Rd != 0 && MemWb_Rd == src)
            return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_st = 0;
        m_hold = RST_HOLD - 1;
        m_scnt = 0;
        m_fcnt = 0;
        m_scnt2 = 0;
    endtask

    task automatic clr();
        OpCode = 6'b111111;
        {IfId_Rs, IfId_Rt, IdEx_Rs, IdEx_Rt, IdEx_WrReg} = '0;
        {ExMem_Rd, MemWb_Rd} = '0;
        {IdEx_Reg_Wr_Control, IdEx_MemRead} = '0;
        {ExMem_Reg_Wr_Control, ExMem_MemRead} = '0;
        {MemWb_Reg_Wr_Control, Ctrl_Branch} = '0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        exp_t e, o;
        logic beq, jmp, urt, lu, bex, bmem, st, fp, fl;
        beq = (OpCode == 6'b000100);
        jmp = (OpCode == 6'b000010);
        urt = beq || OpCode == 6'b000000 || OpCode == 6'b101011;
        lu = IdEx_MemRead && IdEx_WrReg != 0 &&
             (IdEx_WrReg == IfId_Rs || (urt && IdEx_WrReg == IfId_Rt));
        bex = beq && IdEx_Reg_Wr_Control && !IdEx_MemRead &&
              IdEx_WrReg != 0 &&
              (IdEx_WrReg == IfId_Rs || IdEx_WrReg == IfId_Rt);
        bmem = beq && ExMem_MemRead && ExMem_Rd != 0 &&
               (ExMem_Rd == IfId_Rs || ExMem_Rd == IfId_Rt);
        if (RST) model_reset();
        st = (m_st != 1) ? 1'b1 : (lu | bex | bmem);
        fp = (m_st != 0) && !st && (jmp || (beq && Ctrl_Branch));
        fl = (m_st == 0) ? 1'b1 : fp;
        e.ctl = st ? 10'd0 : dec(OpCode);
        e.fwd = {fsel(IdEx_Rs), fsel(IdEx_Rt), fsel(IfId_Rs), fsel(IfId_Rt)};
        e.sfp = {st, fl, fp};
        e.scnt = 16'(m_scnt);
        e.fcnt = 16'(m_fcnt);
        e.scnt2 = 2'(m_scnt2);
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        o.ctl = {RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite,
                 ALU_Src, RegWrite, Alu_Op};
        o.fwd = {FwdRs, FwdRt, Fwd_IfId_Rs, Fwd_IfId_Rt};
        o.sfp = {Stall, Flush, FwdPc};
        check("ctl", 32'(o.ctl), 32'(e.ctl));
        check("fwd", 32'(o.fwd), 32'(e.fwd));
        check("stall_flush_fwdpc", 32'(o.sfp), 32'(e.sfp));
        check("stall_cnt", 32'(stall_cnt), 32'(e.scnt));
        check("flush_cnt", 32'(flush_cnt), 32'(e.fcnt));
        check("stall_cnt_sat", 32'(s_stall_cnt), 32'(e.scnt2));
        @(posedge CLK);
        if (RST) begin
            model_reset();
        end else begin
            if (m_st != 0 && st) begin
                if (m_scnt < 65535) m_scnt++;
                if (m_scnt2 < 3) m_scnt2++;
            end
            if (fp && m_fcnt < 65535) m_fcnt++;
            case (m_st)
                0: if (m_hold == 0) m_st = 1; else m_hold--;
                1: if (lu && beq) m_st = 2;
                default: m_st = 1;
            endcase
        end
        @(negedge CLK);
    endtask

    task automatic lw_r4_beq();
        clr();
        OpCode = 6'b000100;
        IfId_Rs = 5'd4;
        IfId_Rt = 5'd7;
        IdEx_WrReg = 5'd4;
        IdEx_MemRead = 1'b1;
        IdEx_Reg_Wr_Control = 1'b1;
    endtask

    logic [5:0] ops [7];

    initial begin
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b001000,
                6'b000100, 6'b000010, 6'b111111};
        model_reset();
        RST = 1'b1;
        clr();
        @(negedge CLK);
        cycle();
        RST = 1'b0;
        repeat (3) cycle();

        clr();
        OpCode = 6'b000000;
        ExMem_Rd = 5'd5; ExMem_Reg_Wr_Control = 1'b1;
        MemWb_Rd = 5'd5; MemWb_Reg_Wr_Control = 1'b1;
        IdEx_Rs = 5'd5;
        cycle();
        clr();
        OpCode = 6'b101011;
        MemWb_Rd = 5'd6; MemWb_Reg_Wr_Control = 1'b1;
        IdEx_Rt = 5'd6; IfId_Rs = 5'd6;
        ExMem_Rd = 5'd0; ExMem_Reg_Wr_Control = 1'b1;
        cycle();

        clr();
        OpCode = 6'b000000;
        IfId_Rt = 5'd4;
        IdEx_WrReg = 5'd4; IdEx_MemRead = 1'b1;
        cycle();
        IdEx_MemRead = 1'b0;
        cycle();

        lw_r4_beq();
        cycle();
        clr();
        OpCode = 6'b000100;
        Ctrl_Branch = 1'b1;
        cycle();
        cycle();

        clr();
        OpCode = 6'b000010;
        cycle();
        OpCode = 6'b000100;
        IfId_Rs = 5'd3;
        IdEx_WrReg = 5'd3; IdEx_Reg_Wr_Control = 1'b1;
        Ctrl_Branch = 1'b1;
        cycle();
        IdEx_Reg_Wr_Control = 1'b0;
        ExMem_Rd = 5'd3; ExMem_MemRead = 1'b1;
        cycle();

        for (int i = 0; i < 40; i++) begin
            OpCode = ops[$urandom_range(0, 6)];
            IfId_Rs = 5'($urandom_range(0, 3));
            IfId_Rt = 5'($urandom_range(0, 3));
            IdEx_Rs = 5'($urandom_range(0, 3));
            IdEx_Rt = 5'($urandom_range(0, 3));
            IdEx_WrReg = 5'($urandom_range(0, 3));
            ExMem_Rd = 5'($urandom_range(0, 3));
            MemWb_Rd = 5'($urandom_range(0, 3));
            IdEx_Reg_Wr_Control = 1'($urandom_range(0, 1));
            IdEx_MemRead = 1'($urandom_range(0, 1));
            ExMem_Reg_Wr_Control = 1'($urandom_range(0, 1));
            ExMem_MemRead = 1'($urandom_range(0, 1));
            MemWb_Reg_Wr_Control = 1'($urandom_range(0, 1));
            Ctrl_Branch = 1'($urandom_range(0, 1));
            cycle();
        end

        lw_r4_beq();
        cycle();
        while (m_st != 1 && checks < 2000) cycle();
        lw_r4_beq();
        cycle();
        clr();
        #2 RST = 1'b1;
        #1;
        check("async_stall", 32'(Stall), 32'd1);
        check("async_flush", 32'(Flush), 32'd1);
        check("async_stall_cnt", 32'(stall_cnt), 32'd0);
        check("async_flush_cnt", 32'(flush_cnt), 32'd0);
        @(negedge CLK);
        cycle();
        RST = 1'b0;
        repeat (2) cycle();

        clr();
        OpCode = 6'b000000;
        IfId_Rs = 5'd9;
        IdEx_WrReg = 5'd9; IdEx_MemRead = 1'b1;
        repeat (6) cycle();
        clr();
        cycle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Decision-making counterpart of DataPath. It consumes the pipeline-register tags DataPath exports (OpCode, Rs/Rt/Rd per stage, write/read enables, Ctrl_Branch).
- It drives every control, forwarding, Stall, Flush and FwdPc input of DataPath, replacing bench-driven stimulus.
- It contains the main opcode decoder, the EX- and ID-stage forwarding selects, a hazard stall FSM, and saturating performance counters.

Parameters:
RST_HOLD, 2, cycles Stall and Flush stay high after reset release (pipeline drain)
CNT_W, 16, width of the stall and flush event counters

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  reset, asynchronous, active-high
OpCode  in  6  IF/ID instruction opcode
IfId_Rs, IfId_Rt  in  5 each  IF/ID source registers
IdEx_Rs, IdEx_Rt  in  5 each  ID/EX source registers
IdEx_WrReg  in  5  ID/EX destination after the RegDst mux
IdEx_Reg_Wr_Control, IdEx_MemRead  in  1 each  ID/EX RegWrite and MemRead
ExMem_Rd  in  5  EX/MEM destination
ExMem_Reg_Wr_Control, ExMem_MemRead  in  1 each  EX/MEM RegWrite and MemRead
MemWb_Rd  in  5  MEM/WB destination
MemWb_Reg_Wr_Control  in  1  MEM/WB RegWrite
Ctrl_Branch  in  1  ID-stage comparator result: branch condition true
RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite, ALU_Src, RegWrite  out  1 each  main control
Alu_Op  out  2  ALU op class
FwdRs, FwdRt  out  2 each  EX operand select
Fwd_IfId_Rs, Fwd_IfId_Rt  out  2 each  ID comparator operand select
Stall  out  1  freeze PC and IF/ID, inject bubble
Flush  out  1  zero IF/ID
FwdPc  out  1  select branch/jump target as next PC
stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

Behaviour:

Decode (combinational from OpCode):
- 000000 R-type: RegDst=1, RegWrite=1, Alu_Op=10.
- 100011 lw: ALU_Src=1, MemRead=1, MemtoReg=1, RegWrite=1, Alu_Op=00.
- 101011 sw: ALU_Src=1, MemWrite=1, Alu_Op=00.
- 001000 addi: ALU_Src=1, RegWrite=1, Alu_Op=00.
- 000100 beq: Branch=1, Alu_Op=01.
- 000010 j: Jump=1.
- Any other opcode: all controls 0.
- When Stall=1, all controls are forced to 0 (bubble).

Rt as source:
- uses_rt = 1 for R-type, sw and beq.

EX forwarding (FwdRs; FwdRt identical using IdEx_Rt):
- 10 if ExMem_Reg_Wr_Control, ExMem_Rd!=0 and ExMem_Rd==IdEx_Rs.
- Otherwise 01 if MemWb_Reg_Wr_Control, MemWb_Rd!=0 and MemWb_Rd==IdEx_Rs.
- Otherwise 00.
- EX/MEM has priority over MEM/WB.

ID forwarding (Fwd_IfId_Rs/Rt): same rule, compared against IfId_Rs/IfId_Rt.

Hazard detection (combinational):
- lu = IdEx_MemRead, IdEx_WrReg!=0, and IdEx_WrReg matches IfId_Rs, or matches IfId_Rt with uses_rt.
- bex = beq in ID, IdEx_Reg_Wr_Control, not IdEx_MemRead, IdEx_WrReg!=0, and IdEx_WrReg matches IfId_Rs/Rt.
- bmem = beq in ID, ExMem_MemRead, ExMem_Rd!=0, and ExMem_Rd matches IfId_Rs/Rt.

FSM (registered state; RST forces HOLD with hold counter = RST_HOLD-1):
- HOLD: Stall=1, Flush=1, FwdPc=0. Counter decrements each cycle; at 0, next state is RUN.
- RUN: Stall = lu | bex | bmem. If lu with beq in ID, next state is BR2, otherwise stay in RUN.
- BR2: Stall=1 unconditionally, regardless of inputs. Next state is RUN. This gives a load-to-dependent-beq total of exactly 2 stall cycles.

Redirect (all states except HOLD):
- FwdPc = ~Stall & (Jump_dec | (Branch_dec & Ctrl_Branch)).
- Flush = FwdPc.
- Stall always beats redirect: while Stall=1, no Flush and no FwdPc.

Counters:
- stall_cnt increments on each Stall=1 cycle in RUN or BR2 (not HOLD).
- flush_cnt increments on each FwdPc=1 cycle.
- Both saturate at all-ones and clear only on RST.

Reset values:
- All controls, Fwd selects, FwdPc and counters are 0.
- Stall=1 and Flush=1, held for the HOLD state.
- RST asserted mid-stall aborts BR2 immediately.

Register 0 is never a forwarding or hazard source.

Test Plan:
1. Reset release with RST_HOLD=2 -> Stall=Flush=1 for exactly 2 rising edges, then 0; stall_cnt stays 0.
2. R-type in ID, ExMem_Rd=5 (RegWrite) and MemWb_Rd=5 (RegWrite), IdEx_Rs=5, IdEx_Rt=0 -> FwdRs=10, FwdRt=00, RegDst=1, Alu_Op=10, Stall=0.
3. lw r4 in EX (IdEx_WrReg=4, IdEx_MemRead=1), R-type in ID with IfId_Rt=4 -> Stall=1 for 1 cycle, all controls 0 that cycle, stall_cnt=1.
4. lw r4 in EX, beq using r4 in ID -> Stall=1 for 2 consecutive cycles (RUN then BR2), Flush=0 throughout, stall_cnt=2.
5. beq with Ctrl_Branch=1 and no hazard -> FwdPc=1 and Flush=1 for one cycle, flush_cnt=1. Opcode 000010 -> same response independent of Ctrl_Branch.
6. Assert RST during BR2 -> state returns to HOLD asynchronously, counters read 0 before the next edge; force CNT_W=2 with continuous stalls -> stall_cnt saturates at 3.
